// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble).
// One ADJ/SHIFT pair per input bit; result and DONE are registered at the final shift.
module bcd_converter_seq #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [WIDTH-1:0]      BIN_IN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCD_OUT
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {StIdle, StLoad, StAdj, StShift, StFinish} state_e;

    state_e                state_q, state_d;
    logic                  start_prev_q;
    logic [WIDTH-1:0]      bin_q, bin_d;
    logic [4*DIGITS-1:0]   scratch_q, scratch_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  start_rise;

    assign start_rise = START & ~start_prev_q;

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;

        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                bin_d     = BIN_IN;
                scratch_d = '0;
                cnt_d     = CntW'(WIDTH);
                state_d   = StAdj;
            end
            StAdj: begin
                // Each digit adjusted independently; no carry crosses nibbles.
                for (int i = 0; i < int'(DIGITS); i++) begin
                    if (scratch_q[4*i +: 4] >= 4'd5) begin
                        scratch_d[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
                    end
                end
                state_d = StShift;
            end
            StShift: begin
                {scratch_d, bin_d} = {scratch_q[4*DIGITS-2:0], bin_q, 1'b0};
                cnt_d = cnt_q - CntW'(1);
                if (cnt_d == '0) begin
                    bcd_d   = scratch_d;
                    state_d = StFinish;
                end else begin
                    state_d = StAdj;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StFinish);
    end

    // Previous-START resets high so a level already present at release is not a rise.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= StIdle;
            start_prev_q <= 1'b1;
            bin_q        <= '0;
            scratch_q    <= '0;
            cnt_q        <= '0;
            bcd_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= START;
            bin_q        <= bin_d;
            scratch_q    <= scratch_d;
            cnt_q        <= cnt_d;
            bcd_q        <= bcd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign BCD_OUT = bcd_q;

endmodule

// File: doc/bcd_converter_seq.md
BCD_CONVERTER_SEQ -- requirements
Module: bcd_converter_seq

Interface
REQ-001 Parameter WIDTH, 16, width of the unsigned binary input (the root result word).
REQ-002 Parameter DIGITS, 5, number of 4-bit BCD output digits; DIGITS SHALL satisfy 10^DIGITS > 2^WIDTH-1.
REQ-003 CLK  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 START  input  1  conversion request, driven by the root controller's DONE level (may stay high for many cycles).
REQ-006 BIN_IN  input  WIDTH  unsigned binary value to convert, valid when START rises.
REQ-007 BUSY  output  1  high while a conversion is in progress.
REQ-008 DONE  output  1  one-cycle pulse marking a new BCD_OUT value.
REQ-009 BCD_OUT  output  4*DIGITS  packed BCD result, most significant digit in the top nibble.

Function
REQ-010 A conversion SHALL be triggered only by a START rising edge: START=1 at a clock edge while the registered previous START = 0.
REQ-011 The block SHALL implement shift-add-3 (double dabble) with states IDLE, LOAD, ADJ, SHIFT, FINISH.
REQ-012 IDLE: BUSY=0; a detected START rise at edge E0 SHALL move the FSM to LOAD; otherwise the FSM SHALL stay in IDLE.
REQ-013 LOAD (edge E1): BIN_IN captured into the shift register, BCD scratch cleared, bit counter set to WIDTH, then go to ADJ.
REQ-014 ADJ: every scratch digit >= 5 SHALL have 3 added (all digits in parallel, 4-bit arithmetic, no carry between digits), then go to SHIFT.
REQ-015 SHIFT: {scratch, binary} SHALL shift left by one and the counter SHALL decrement; counter != 0 after the shift -> ADJ; counter == 0 -> FINISH.
REQ-016 At the edge performing the final SHIFT (E(2*WIDTH+1), edge 33 for WIDTH=16), BCD_OUT SHALL load the final scratch value and DONE SHALL be registered high.
REQ-017 FINISH SHALL last exactly one cycle with DONE=1, then return to IDLE; DONE SHALL be 0 in every other cycle.
REQ-018 BUSY SHALL be 1 in LOAD, ADJ, SHIFT and FINISH, and 0 in IDLE.
REQ-019 BCD_OUT SHALL hold its last value between conversions and SHALL change only at the REQ-016 edge.
REQ-020 START rises while BUSY=1 SHALL be ignored and not queued.
REQ-021 A START held high continuously SHALL produce exactly one conversion.
REQ-022 Changes on BIN_IN after the LOAD edge SHALL NOT affect the running conversion.
REQ-023 Outputs SHALL be driven directly from registers (no combinational path from inputs to outputs).

Reset
REQ-024 RST=1 SHALL immediately force FSM=IDLE, BUSY=0, DONE=0, BCD_OUT=0, scratch, shift register and counter = 0, independent of CLK.
REQ-025 On RST the previous-START register SHALL be set to 1, so a START already high at reset release is not treated as a rise.
REQ-026 RST asserted mid-conversion SHALL abort it without any DONE pulse; the next conversion SHALL require a fresh START rise.

Verification
REQ-027 BIN_IN=1234, START pulsed high 1 cycle (rise sampled at E0) -> BUSY=1 from E0; DONE=1 for one cycle after E33; BCD_OUT=0x01234.
REQ-028 Run BIN_IN=0 -> BCD_OUT=0x00000 with a DONE pulse; then run BIN_IN=65535 -> BCD_OUT=0x65535.
REQ-029 START held high for 31 cycles with BIN_IN=9 -> exactly one DONE pulse; BCD_OUT=0x00009.
REQ-030 BIN_IN=500 converting; at E10, pulse START again with BIN_IN=7 -> single DONE at E33; BCD_OUT=0x00500; no second conversion follows.
REQ-031 BIN_IN=4321 converting; assert RST between clock edges at E12 -> BUSY, DONE and BCD_OUT are 0 at once; no DONE pulse follows; release RST with START high -> no conversion until START falls and rises again.
REQ-032 Random sweep of 1000 BIN_IN values against a reference model -> every BCD_OUT matches; every DONE appears exactly 33 edges after the START-rise edge.
